uart_rx: RTL

UART receiver, the counterpart of uart_tx. It deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous rx line into bytes. Each byte is presented with a one-cycle valid strobe. It sits between the board RX pin and the command/data front end of the vector accelerator, and uses the same CLK_FREQ/BAUD parameterisation as uart_tx so the two can share a link.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width and the
// clock-per-bit derivation used by uart_rx and uart_tx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Whole clk cycles per line bit; callers need at least 4.
  function automatic int clk_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(
    input int clk_freq,
    input int baud
  );
    return clk_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser for asynchronous inputs.
// Ports: clk, rst (async active-low), d (async in), q (synced out).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx line in, data_out with one-cycle valid.
// Ports: clk, rst (async active-low), rx, data_out, valid, busy, frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err
);

  localparam int CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT    = half_bit(CLK_FREQ, BAUD);
  localparam int CW          = $clog2(CLK_PER_BIT);
  localparam int IW          = $clog2(DATA_BITS);

  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [IW-1:0] LAST    = IW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A high line at mid-start was a glitch.
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            // Leave at mid-stop so a gapless next start is caught.
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
              data_out <= shreg;
              valid    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
